core_obi2axi_bridge: RTL and testbench
======================================

Name: core_obi2axi_bridge

Overview:
- Converts the core data-side OBI manager traffic into single-beat AXI4 transactions. This is the traffic the OBI crossbar routes to the L2 window, 0x2000_0000–0x2FFF_FFFF.
- Sits directly downstream of the tile's OBI crossbar slave port 1 and upstream of the tile AXI data crossbar.
- Holds at most one outstanding transaction, matching the crossbar's one-transaction limit.

Parameters:
- ADDR_W, 32, address width (OBI and AXI)
- DATA_W, 32, data width; STRB_W = DATA_W/8
- AXI_ID_W, 2, AXI ID width
- AXI_ID, 0, constant ID driven on AW/AR
- AID_W, 1, OBI aid/rid width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  ADDR_W  byte address
- obi_we_i  in  1  1 = write
- obi_be_i  in  STRB_W  byte enables
- obi_wdata_i  in  DATA_W  write data
- obi_aid_i  in  AID_W  request ID
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  DATA_W  read data
- obi_rid_o  out  AID_W  response ID
- obi_err_o  out  1  bus error
- axi_aw_valid_o/axi_aw_ready_i  out/in  1  AW handshake
- axi_aw_addr_o  out  ADDR_W  write address
- axi_w_valid_o/axi_w_ready_i  out/in  1  W handshake
- axi_w_data_o  out  DATA_W  write data
- axi_w_strb_o  out  STRB_W  write strobes
- axi_b_valid_i/axi_b_ready_o  in/out  1  B handshake
- axi_b_resp_i  in  2  write response
- axi_ar_valid_o/axi_ar_ready_i  out/in  1  AR handshake
- axi_ar_addr_o  out  ADDR_W  read address
- axi_r_valid_i/axi_r_ready_o  in/out  1  R handshake
- axi_r_data_i  in  DATA_W  read data
- axi_r_resp_i  in  2  read response
- axi_id_o  out  AXI_ID_W  constant AXI_ID, used on AW and AR

Behaviour:
- Fixed AXI fields, driven combinationally:
  - len = 0, size = 3'b010, burst = INCR, lock = 0, cache = 0, prot = 0, w_last = 1.
  - Address is obi_addr with bits [1:0] cleared.
  - w_strb = registered be.
- State machine: IDLE, WR, WAIT_B, RD, WAIT_R, RSP.
- IDLE:
  - obi_gnt_o = obi_req_i. obi_gnt_o is combinational and is 1 only in IDLE.
  - On req&gnt, register addr, we, be, wdata and aid.
  - Go to WR if we=1, else to RD.
- WR:
  - aw_valid and w_valid both assert in the first WR cycle.
  - Each drops independently after its own handshake, tracked by aw_done and w_done flags.
  - A valid never drops before its ready; the payload is stable while valid is high.
  - When both handshakes are complete (same cycle allowed), go to WAIT_B.
- WAIT_B:
  - b_ready = 1.
  - On b_valid: latch err = (b_resp[1] != 0), set rdata = 0, go to RSP.
- RD:
  - ar_valid = 1 until ar_ready, then go to WAIT_R.
- WAIT_R:
  - r_ready = 1.
  - On r_valid: latch r_data and err = (r_resp[1] != 0), go to RSP.
- RSP:
  - obi_rvalid_o = 1 for exactly one cycle, with the latched rdata/err and rid = the registered aid.
  - Go to IDLE. The next grant is possible in the following cycle.
- b_ready and r_ready are 0 outside WAIT_B and WAIT_R respectively.
- Latency with zero-wait AXI:
  - Grant in cycle 0.
  - AW/W/AR valid in cycle 1.
  - B/R accepted in cycle 2 at the earliest.
  - rvalid in cycle 3.
- OKAY and EXOKAY map to err = 0. SLVERR and DECERR map to err = 1.
- Reset, at any time including mid-transaction:
  - State returns to IDLE and all registers clear.
  - All valid, ready and rvalid outputs go to 0; rdata, rid and err go to 0.
  - A pending AXI transaction is abandoned.
- obi_req_i with no grant (state not IDLE) is ignored. The core holds it until grant, per OBI.
- Unexpected b_valid or r_valid outside its WAIT state is not acknowledged (ready = 0).

Test Plan:
- Read, zero-wait slave: addr 0x2000_0104, slave returns 0xDEAD_BEEF/OKAY.
  - ar_addr = 0x2000_0104.
  - rvalid 3 cycles after grant with rdata 0xDEAD_BEEF, err = 0, rid = the request aid.
- Write with be = 4'b0110, wdata 0x1234_5678, where W ready arrives 3 cycles after AW ready.
  - aw_valid drops after its handshake while w_valid holds with stable data.
  - w_strb = 0110.
  - rvalid once, after B is accepted.
- Read returning r_resp = DECERR (2'b11) -> obi_err_o = 1 on the rvalid cycle.
- Write returning b_resp = SLVERR -> obi_err_o = 1 on the rvalid cycle.
- Back-to-back: core holds req high for a second read while the first is outstanding.
  - gnt stays 0 until the cycle after RSP.
  - Exactly one rvalid per grant.
- rst_ni asserted low in WAIT_R with r_valid pending.
  - All outputs go to 0 immediately.
  - After release, the bridge is in IDLE and a new read completes normally.

Source files
------------

// File: rtl/core_obi2axi_bridge.sv
// OBI (core data side) to AXI4 single-beat bridge with one outstanding transaction.
// Request fields are captured on grant; the AXI side is driven from those registers.
module core_obi2axi_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int AXI_ID_W = 2,
  parameter int AXI_ID   = 0,
  parameter int AID_W    = 1,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // OBI subordinate side
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic                obi_we_i,
  input  logic [STRB_W-1:0]   obi_be_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  input  logic [AID_W-1:0]    obi_aid_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic [AID_W-1:0]    obi_rid_o,
  output logic                obi_err_o,
  // AXI manager side
  output logic                axi_aw_valid_o,
  input  logic                axi_aw_ready_i,
  output logic [ADDR_W-1:0]   axi_aw_addr_o,
  output logic                axi_w_valid_o,
  input  logic                axi_w_ready_i,
  output logic [DATA_W-1:0]   axi_w_data_o,
  output logic [STRB_W-1:0]   axi_w_strb_o,
  output logic                axi_w_last_o,
  input  logic                axi_b_valid_i,
  output logic                axi_b_ready_o,
  input  logic [1:0]          axi_b_resp_i,
  output logic                axi_ar_valid_o,
  input  logic                axi_ar_ready_i,
  output logic [ADDR_W-1:0]   axi_ar_addr_o,
  input  logic                axi_r_valid_i,
  output logic                axi_r_ready_o,
  input  logic [DATA_W-1:0]   axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  output logic [AXI_ID_W-1:0] axi_id_o,
  // fixed attributes shared by AW and AR
  output logic [7:0]          axi_len_o,
  output logic [2:0]          axi_size_o,
  output logic [1:0]          axi_burst_o,
  output logic                axi_lock_o,
  output logic [3:0]          axi_cache_o,
  output logic [2:0]          axi_prot_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_RSP
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [STRB_W-1:0]   r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [AID_W-1:0]    r_aid;
  logic                r_aw_done, r_w_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  assign axi_aw_addr_o = r_addr;
  assign axi_ar_addr_o = r_addr;
  assign axi_w_data_o  = r_wdata;
  assign axi_w_strb_o  = r_be;
  assign axi_w_last_o  = 1'b1;
  assign axi_id_o      = AXI_ID_W'(AXI_ID);
  assign axi_len_o     = 8'd0;
  assign axi_size_o    = 3'b010;
  assign axi_burst_o   = 2'b01;
  assign axi_lock_o    = 1'b0;
  assign axi_cache_o   = 4'd0;
  assign axi_prot_o    = 3'd0;
  assign obi_rdata_o   = r_rdata;
  assign obi_rid_o     = r_aid;
  assign obi_err_o     = r_err;

  always_comb begin
    w_state_nxt    = r_state;
    obi_gnt_o      = 1'b0;
    obi_rvalid_o   = 1'b0;
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_r_ready_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) w_state_nxt = obi_we_i ? S_WR : S_RD;
      end
      S_WR: begin
        // AW and W complete independently; leave once both are done
        axi_aw_valid_o = !r_aw_done;
        axi_w_valid_o  = !r_w_done;
        if ((r_aw_done || axi_aw_ready_i) && (r_w_done || axi_w_ready_i))
          w_state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        axi_b_ready_o = 1'b1;
        if (axi_b_valid_i) w_state_nxt = S_RSP;
      end
      S_RD: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) w_state_nxt = S_WAIT_R;
      end
      S_WAIT_R: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        obi_rvalid_o = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_aid     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (obi_gnt_o) begin
        r_addr    <= obi_addr_i & ~ADDR_W'(3);
        r_be      <= obi_be_i;
        r_wdata   <= obi_wdata_i;
        r_aid     <= obi_aid_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (axi_aw_valid_o && axi_aw_ready_i) r_aw_done <= 1'b1;
      if (axi_w_valid_o && axi_w_ready_i)   r_w_done  <= 1'b1;
      // SLVERR/DECERR both have resp[1] set
      if (axi_b_ready_o && axi_b_valid_i) begin
        r_err   <= (axi_b_resp_i & 2'b10) != 2'b00;
        r_rdata <= '0;
      end
      if (axi_r_ready_o && axi_r_valid_i) begin
        r_err   <= (axi_r_resp_i & 2'b10) != 2'b00;
        r_rdata <= axi_r_data_i;
      end
    end
  end

endmodule

// File: tb/tb_core_obi2axi_bridge.sv
// Directed bench for core_obi2axi_bridge: reads, writes, error responses,
// back-to-back requests and mid-transaction reset, with hand-computed expectations.
module tb_core_obi2axi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i, obi_gnt_o, obi_we_i;
  logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
  logic [3:0]  obi_be_i;
  logic [0:0]  obi_aid_i, obi_rid_o;
  logic        obi_rvalid_o, obi_err_o;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0]  w_strb, cache;
  logic [1:0]  b_resp, r_resp, axi_id, burst;
  logic [7:0]  len;
  logic [2:0]  size, prot;
  logic        lock;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  core_obi2axi_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_aid_i(obi_aid_i), .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o),
    .obi_rid_o(obi_rid_o), .obi_err_o(obi_err_o),
    .axi_aw_valid_o(aw_valid), .axi_aw_ready_i(aw_ready), .axi_aw_addr_o(aw_addr),
    .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready), .axi_w_data_o(w_data),
    .axi_w_strb_o(w_strb), .axi_w_last_o(w_last),
    .axi_b_valid_i(b_valid), .axi_b_ready_o(b_ready), .axi_b_resp_i(b_resp),
    .axi_ar_valid_o(ar_valid), .axi_ar_ready_i(ar_ready), .axi_ar_addr_o(ar_addr),
    .axi_r_valid_i(r_valid), .axi_r_ready_o(r_ready), .axi_r_data_i(r_data),
    .axi_r_resp_i(r_resp), .axi_id_o(axi_id),
    .axi_len_o(len), .axi_size_o(size), .axi_burst_o(burst), .axi_lock_o(lock),
    .axi_cache_o(cache), .axi_prot_o(prot)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, then let inputs settle
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0; obi_req_i = 0; obi_we_i = 0; obi_addr_i = 0; obi_wdata_i = 0;
    obi_be_i = 0; obi_aid_i = 0; aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    #12;
    chk("rst_gnt", obi_gnt_o, 0);     chk("rst_rvalid", obi_rvalid_o, 0);
    chk("rst_awv", aw_valid, 0);      chk("rst_wv", w_valid, 0);
    chk("rst_arv", ar_valid, 0);      chk("rst_bready", b_ready, 0);
    chk("rst_rready", r_ready, 0);    chk("rst_rdata", obi_rdata_o, 0);
    chk("const_id", axi_id, 0);       chk("const_len", len, 0);
    chk("const_size", size, 3'b010);  chk("const_burst", burst, 2'b01);
    chk("const_wlast", w_last, 1);    chk("const_misc", {lock, cache, prot}, 0);
    tick(); rst_ni = 1'b1; tick();

    // ---- read, zero-wait ----
    obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h2000_0104; obi_aid_i = 1; #1;
    chk("rd1_gnt", obi_gnt_o, 1);
    tick(); obi_req_i = 0; ar_ready = 1; #1;                    // cycle 1
    chk("rd1_arv", ar_valid, 1);      chk("rd1_araddr", ar_addr, 32'h2000_0104);
    chk("rd1_gnt_busy", obi_gnt_o, 0);
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'hDEAD_BEEF; r_resp = 2'b00; #1; // cycle 2
    chk("rd1_arv_drop", ar_valid, 0); chk("rd1_rready", r_ready, 1);
    chk("rd1_rvalid_early", obi_rvalid_o, 0);
    tick(); r_valid = 0; #1;                                     // cycle 3
    chk("rd1_rvalid", obi_rvalid_o, 1); chk("rd1_rdata", obi_rdata_o, 32'hDEAD_BEEF);
    chk("rd1_err", obi_err_o, 0);     chk("rd1_rid", obi_rid_o, 1);
    chk("rd1_rready_off", r_ready, 0);
    tick();
    chk("rd1_rvalid_once", obi_rvalid_o, 0);

    // ---- write, W ready 3 cycles after AW ready ----
    obi_req_i = 1; obi_we_i = 1; obi_addr_i = 32'h2000_0012; obi_be_i = 4'b0110;
    obi_wdata_i = 32'h1234_5678; obi_aid_i = 0; #1;
    chk("wr1_gnt", obi_gnt_o, 1);
    tick(); obi_req_i = 0; aw_ready = 1; #1;
    chk("wr1_awv", aw_valid, 1);      chk("wr1_wv", w_valid, 1);
    chk("wr1_awaddr", aw_addr, 32'h2000_0010);
    chk("wr1_strb", w_strb, 4'b0110); chk("wr1_wdata", w_data, 32'h1234_5678);
    tick(); aw_ready = 0; #1;
    chk("wr1_awv_drop", aw_valid, 0); chk("wr1_wv_hold", w_valid, 1);
    tick(); #1;
    chk("wr1_wv_hold2", w_valid, 1);  chk("wr1_wdata_stable", w_data, 32'h1234_5678);
    tick(); w_ready = 1; b_valid = 1; #1;                       // spurious B while in WR
    chk("wr1_bready_wr", b_ready, 0); chk("wr1_wv_last", w_valid, 1);
    tick(); w_ready = 0; b_resp = 2'b00; #1;
    chk("wr1_wv_drop", w_valid, 0);   chk("wr1_bready", b_ready, 1);
    chk("wr1_rvalid_early", obi_rvalid_o, 0);
    tick(); b_valid = 0; #1;
    chk("wr1_rvalid", obi_rvalid_o, 1); chk("wr1_err", obi_err_o, 0);
    chk("wr1_rdata", obi_rdata_o, 0); chk("wr1_rid", obi_rid_o, 0);
    tick();
    chk("wr1_rvalid_once", obi_rvalid_o, 0);

    // ---- read returning DECERR, unaligned address ----
    obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h2000_0203; obi_aid_i = 1; #1;
    tick(); obi_req_i = 0; ar_ready = 1; #1;
    chk("rd2_araddr", ar_addr, 32'h2000_0200);
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'h0000_0055; r_resp = 2'b11; #1;
    tick(); r_valid = 0; r_resp = 0; #1;
    chk("rd2_rvalid", obi_rvalid_o, 1); chk("rd2_err", obi_err_o, 1);
    chk("rd2_rdata", obi_rdata_o, 32'h55);
    tick();

    // ---- write returning SLVERR, zero-wait ----
    obi_req_i = 1; obi_we_i = 1; obi_addr_i = 32'h2000_0040; obi_be_i = 4'hF;
    obi_wdata_i = 32'hCAFE_0001; obi_aid_i = 0; #1;
    tick(); obi_req_i = 0; aw_ready = 1; w_ready = 1; #1;
    chk("wr2_awv", aw_valid, 1);      chk("wr2_wv", w_valid, 1);
    tick(); aw_ready = 0; w_ready = 0; b_valid = 1; b_resp = 2'b10; #1;
    chk("wr2_bready", b_ready, 1);    chk("wr2_wv_off", w_valid, 0);
    tick(); b_valid = 0; b_resp = 0; #1;
    chk("wr2_rvalid", obi_rvalid_o, 1); chk("wr2_err", obi_err_o, 1);
    chk("wr2_rdata", obi_rdata_o, 0);
    tick();

    // ---- back-to-back reads, req held high ----
    obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h2000_1000; obi_aid_i = 0; #1;
    chk("b2b_gnt1", obi_gnt_o, 1);
    tick(); obi_addr_i = 32'h2000_2000; obi_aid_i = 1; ar_ready = 1; #1;
    chk("b2b_gnt_rd", obi_gnt_o, 0);  chk("b2b_araddr1", ar_addr, 32'h2000_1000);
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'h1111_1111; #1;
    chk("b2b_gnt_waitr", obi_gnt_o, 0);
    tick(); r_valid = 0; #1;
    chk("b2b_gnt_rsp", obi_gnt_o, 0); chk("b2b_rvalid1", obi_rvalid_o, 1);
    chk("b2b_rdata1", obi_rdata_o, 32'h1111_1111); chk("b2b_rid1", obi_rid_o, 0);
    tick(); #1;
    chk("b2b_gnt2", obi_gnt_o, 1);    chk("b2b_rvalid_gap", obi_rvalid_o, 0);
    tick(); obi_req_i = 0; ar_ready = 1; #1;
    chk("b2b_araddr2", ar_addr, 32'h2000_2000); chk("b2b_rvalid_rd", obi_rvalid_o, 0);
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'h2222_2222; #1;
    tick(); r_valid = 0; #1;
    chk("b2b_rvalid2", obi_rvalid_o, 1); chk("b2b_rdata2", obi_rdata_o, 32'h2222_2222);
    chk("b2b_rid2", obi_rid_o, 1);
    tick();
    chk("b2b_rvalid_end", obi_rvalid_o, 0);

    // ---- reset in WAIT_R with R pending ----
    obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h2000_0300; obi_aid_i = 1; #1;
    tick(); obi_req_i = 0; ar_ready = 1; #1;
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'hAAAA_AAAA; #1;
    chk("rst_mid_rready_pre", r_ready, 1);
    rst_ni = 1'b0; #1;
    chk("rst_mid_rready", r_ready, 0); chk("rst_mid_arv", ar_valid, 0);
    chk("rst_mid_rvalid", obi_rvalid_o, 0); chk("rst_mid_rdata", obi_rdata_o, 0);
    chk("rst_mid_rid", obi_rid_o, 0);  chk("rst_mid_err", obi_err_o, 0);
    tick(); r_valid = 0; rst_ni = 1'b1; #1;
    chk("rst_mid_rvalid_after", obi_rvalid_o, 0);
    obi_req_i = 1; obi_addr_i = 32'h2000_0400; obi_aid_i = 0; #1;
    chk("post_gnt", obi_gnt_o, 1);
    tick(); obi_req_i = 0; ar_ready = 1; #1;
    chk("post_araddr", ar_addr, 32'h2000_0400);
    tick(); ar_ready = 0; r_valid = 1; r_data = 32'h0BAD_F00D; r_resp = 2'b01; #1;
    tick(); r_valid = 0; r_resp = 0; #1;
    chk("post_rvalid", obi_rvalid_o, 1); chk("post_rdata", obi_rdata_o, 32'h0BAD_F00D);
    chk("post_err", obi_err_o, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
